// File: rtl/mmio_pkg.sv
// Shared types and helpers for the mmio_interconnect data-side bus engine.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int ERR_CNT_W = 8;

    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational priority address decoder: lowest matching slot wins, size 0 disables a slot.
module mmio_addr_decode
    import mmio_pkg::*;
#(
    parameter int                      N_SLV    = 4,
    parameter int                      ADDR_W   = 32,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_SIZE = '0
) (
    input  logic [ADDR_W-1:0]        addr,
    output logic                     hit,
    output logic [slot_w(N_SLV)-1:0] slot,
    output logic [ADDR_W-1:0]        offset
);

    localparam int SW = slot_w(N_SLV);

    logic [N_SLV-1:0] match;
    logic [ADDR_W:0]  addr_x;

    assign addr_x = {1'b0, addr};

    // One extra bit on base+size keeps a slot that ends at the top of memory from wrapping to 0.
    for (genvar i = 0; i < N_SLV; i++) begin : g_match
        localparam logic [ADDR_W:0] BASE_X = {1'b0, SLV_BASE[i*ADDR_W +: ADDR_W]};
        localparam logic [ADDR_W:0] SIZE_X = {1'b0, SLV_SIZE[i*ADDR_W +: ADDR_W]};
        assign match[i] = (SIZE_X != '0) && (addr_x >= BASE_X) && (addr_x < BASE_X + SIZE_X);
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        hit    = 1'b0;
        slot   = '0;
        offset = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit    = 1'b1;
                slot   = SW'(i);
                offset = addr - SLV_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/mmio_interconnect.sv
// Registered, handshaked MMIO interconnect between one master and N_SLV slaves.
// Optional build macro MMIO_TIMEOUT_EN bounds slave wait-states to TIMEOUT cycles.
module mmio_interconnect
    import mmio_pkg::*;
#(
    parameter int                      N_SLV    = 4,
    parameter int                      ADDR_W   = 32,
    parameter int                      DATA_W   = 32,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {32'h0001_0008, 32'h0001_0004,
                                                   32'h0001_0000, 32'h0000_0000},
    parameter logic [N_SLV*ADDR_W-1:0] SLV_SIZE = {32'd8, 32'd4, 32'd4, 32'h0001_0000},
    parameter int                      TIMEOUT  = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [ADDR_W-1:0]       m_addr_i,
    input  logic [DATA_W-1:0]       m_wdata_i,
    input  logic                    m_re_i,
    input  logic                    m_we_i,
    output logic                    m_busy_o,
    output logic                    m_ready_o,
    output logic                    m_err_o,
    output logic [DATA_W-1:0]       m_rdata_o,
    output logic [N_SLV-1:0]        s_re_o,
    output logic [N_SLV-1:0]        s_we_o,
    output logic [ADDR_W-1:0]       s_addr_o,
    output logic [DATA_W-1:0]       s_wdata_o,
    input  logic [N_SLV*DATA_W-1:0] s_rdata_i,
    input  logic [N_SLV-1:0]        s_ready_i,
    output logic [ADDR_W-1:0]       err_addr_o,
    output logic [ERR_CNT_W-1:0]    err_cnt_o
);

    localparam int SW = slot_w(N_SLV);

    logic              dec_hit;
    logic [SW-1:0]     dec_slot;
    logic [ADDR_W-1:0] dec_off;
    logic [N_SLV-1:0]  dec_onehot;

    state_e            state;
    logic [SW-1:0]     slot_q;
    logic              op_rd;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;

`ifdef MMIO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]     tmo_cnt;
    logic [ADDR_W-1:0] addr_q;
`endif

    mmio_addr_decode #(
        .N_SLV   (N_SLV),
        .ADDR_W  (ADDR_W),
        .SLV_BASE(SLV_BASE),
        .SLV_SIZE(SLV_SIZE)
    ) u_decode (
        .addr  (m_addr_i),
        .hit   (dec_hit),
        .slot  (dec_slot),
        .offset(dec_off)
    );

    // Only the latched slot's ready and read data are ever looked at.
    always_comb begin
        dec_onehot = '0;
        sel_ready  = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < N_SLV; i++) begin
            dec_onehot[i] = (dec_slot == SW'(i));
            if (slot_q == SW'(i)) begin
                sel_ready = s_ready_i[i];
                sel_rdata = s_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state      <= IDLE;
            slot_q     <= '0;
            op_rd      <= 1'b0;
            m_busy_o   <= 1'b0;
            m_ready_o  <= 1'b0;
            m_err_o    <= 1'b0;
            m_rdata_o  <= '0;
            s_re_o     <= '0;
            s_we_o     <= '0;
            s_addr_o   <= '0;
            s_wdata_o  <= '0;
            err_addr_o <= '0;
            err_cnt_o  <= '0;
`ifdef MMIO_TIMEOUT_EN
            tmo_cnt    <= '0;
            addr_q     <= '0;
`endif
        end else begin
            m_ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_re_i || m_we_i) begin
                        m_busy_o  <= 1'b1;
                        op_rd     <= m_re_i;
                        slot_q    <= dec_slot;
                        s_wdata_o <= m_wdata_i;
`ifdef MMIO_TIMEOUT_EN
                        addr_q    <= m_addr_i;
                        tmo_cnt   <= '0;
`endif
                        // Simultaneous read and write is treated like a decode miss: no slave sees it.
                        if ((m_re_i && m_we_i) || !dec_hit) begin
                            state      <= RESP;
                            m_ready_o  <= 1'b1;
                            m_err_o    <= 1'b1;
                            m_rdata_o  <= '0;
                            err_addr_o <= m_addr_i;
                            err_cnt_o  <= sat_inc(err_cnt_o);
                        end else begin
                            state    <= ACCESS;
                            s_addr_o <= dec_off;
                            s_re_o   <= m_re_i ? dec_onehot : '0;
                            s_we_o   <= m_we_i ? dec_onehot : '0;
                        end
                    end
                end

                ACCESS: begin
                    if (sel_ready) begin
                        state     <= RESP;
                        s_re_o    <= '0;
                        s_we_o    <= '0;
                        m_ready_o <= 1'b1;
                        m_err_o   <= 1'b0;
                        if (op_rd) begin
                            m_rdata_o <= sel_rdata;
                        end
`ifdef MMIO_TIMEOUT_EN
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        state      <= RESP;
                        s_re_o     <= '0;
                        s_we_o     <= '0;
                        m_ready_o  <= 1'b1;
                        m_err_o    <= 1'b1;
                        m_rdata_o  <= '0;
                        err_addr_o <= addr_q;
                        err_cnt_o  <= sat_inc(err_cnt_o);
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end

                RESP: begin
                    state    <= IDLE;
                    m_busy_o <= 1'b0;
                    m_err_o  <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    m_busy_o <= 1'b0;
                    s_re_o   <= '0;
                    s_we_o   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed self-checking bench for mmio_interconnect; covers both MMIO_TIMEOUT_EN builds.
module tb_mmio_interconnect;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [31:0]  m_addr_i;
    logic [31:0]  m_wdata_i;
    logic         m_re_i;
    logic         m_we_i;
    logic         m_busy_o;
    logic         m_ready_o;
    logic         m_err_o;
    logic [31:0]  m_rdata_o;
    logic [3:0]   s_re_o;
    logic [3:0]   s_we_o;
    logic [31:0]  s_addr_o;
    logic [31:0]  s_wdata_o;
    logic [127:0] s_rdata_i;
    logic [3:0]   s_ready_i;
    logic [31:0]  err_addr_o;
    logic [7:0]   err_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    mmio_interconnect dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .m_addr_i  (m_addr_i),
        .m_wdata_i (m_wdata_i),
        .m_re_i    (m_re_i),
        .m_we_i    (m_we_i),
        .m_busy_o  (m_busy_o),
        .m_ready_o (m_ready_o),
        .m_err_o   (m_err_o),
        .m_rdata_o (m_rdata_o),
        .s_re_o    (s_re_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_wdata_o (s_wdata_o),
        .s_rdata_i (s_rdata_i),
        .s_ready_i (s_ready_i),
        .err_addr_o(err_addr_o),
        .err_cnt_o (err_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a one-cycle strobe in cycle T; returns at T+1.
    task automatic start(input logic re, input logic we, input logic [31:0] addr,
                         input logic [31:0] data);
        m_re_i    = re;
        m_we_i    = we;
        m_addr_i  = addr;
        m_wdata_i = data;
        tick();
        m_re_i = 1'b0;
        m_we_i = 1'b0;
    endtask

    initial begin
        logic seen;
        int   cyc;

        reset_i   = 1'b0;
        m_addr_i  = '0;
        m_wdata_i = '0;
        m_re_i    = 1'b0;
        m_we_i    = 1'b0;
        s_ready_i = 4'hF;
        s_rdata_i = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
        tick();
        tick();
        check("por_busy", m_busy_o, 0);
        check("por_ready_err", {m_ready_o, m_err_o}, 0);
        check("por_strobes", {s_re_o, s_we_o}, 0);
        check("por_err_cnt", err_cnt_o, 0);
        reset_i = 1'b1;
        tick();

        // Reset while slot 0 is stalled in ACCESS
        s_ready_i = 4'b1110;
        start(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        check("stall_s_re", s_re_o, 4'b0001);
        check("stall_s_addr", s_addr_o, 32'h40);
        tick();
        check("stall_busy", m_busy_o, 1);
        reset_i = 1'b0;
        tick();
        check("midrst_s_re", s_re_o, 0);
        check("midrst_busy", m_busy_o, 0);
        check("midrst_ready", m_ready_o, 0);
        check("midrst_s_addr", s_addr_o, 0);
        reset_i   = 1'b1;
        s_ready_i = 4'hF;
        seen      = 1'b0;
        repeat (5) begin
            tick();
            seen |= m_ready_o;
        end
        check("midrst_no_ready", seen, 0);

        // Zero-wait read of slot 1
        start(1'b1, 1'b0, 32'h0001_0000, 32'h0);
        check("rd1_s_re", s_re_o, 4'b0010);
        check("rd1_s_addr", s_addr_o, 32'h0);
        check("rd1_early_ready", m_ready_o, 0);
        tick();
        check("rd1_ready", m_ready_o, 1);
        check("rd1_rdata", m_rdata_o, 32'hDEAD_BEEF);
        check("rd1_err", m_err_o, 0);
        check("rd1_s_re_drop", s_re_o, 0);
        tick();
        check("rd1_ready_pulse", m_ready_o, 0);
        check("rd1_idle", m_busy_o, 0);

        // Last word of slot 0 and an offset inside slot 3
        start(1'b1, 1'b0, 32'h0000_FFFC, 32'h0);
        check("rd0_s_re", s_re_o, 4'b0001);
        check("rd0_s_addr", s_addr_o, 32'h0000_FFFC);
        tick();
        check("rd0_rdata", m_rdata_o, 32'h1111_1111);
        tick();
        start(1'b1, 1'b0, 32'h0001_000C, 32'h0);
        check("rd3_s_re", s_re_o, 4'b1000);
        check("rd3_s_addr", s_addr_o, 32'h4);
        tick();
        check("rd3_rdata", m_rdata_o, 32'h3333_3333);
        tick();

        // Write to slot 3 with three wait-states
        s_ready_i = 4'b0111;
        start(1'b0, 1'b1, 32'h0001_0008, 32'h12);
        for (int i = 1; i <= 4; i++) begin
            check("ws_s_we", s_we_o, 4'b1000);
            check("ws_s_addr", s_addr_o, 32'h0);
            check("ws_s_wdata", s_wdata_o, 32'h12);
            check("ws_no_ready", m_ready_o, 0);
            if (i == 4) s_ready_i = 4'hF;
            tick();
        end
        check("ws_ready", m_ready_o, 1);
        check("ws_err", m_err_o, 0);
        check("ws_rdata_hold", m_rdata_o, 32'h3333_3333);
        check("ws_s_we_drop", s_we_o, 0);
        tick();

        // Unmapped read
        start(1'b1, 1'b0, 32'h0002_0000, 32'h0);
        check("unm_ready", m_ready_o, 1);
        check("unm_err", m_err_o, 1);
        check("unm_rdata", m_rdata_o, 0);
        check("unm_err_addr", err_addr_o, 32'h0002_0000);
        check("unm_err_cnt", err_cnt_o, 1);
        tick();

        // One byte past the end of slot 3
        start(1'b1, 1'b0, 32'h0001_0010, 32'h0);
        check("end3_err", m_err_o, 1);
        check("end3_no_strobe", s_re_o, 0);
        check("end3_err_cnt", err_cnt_o, 2);
        tick();

        // Read and write strobes together
        start(1'b1, 1'b1, 32'h0001_0004, 32'h55);
        check("both_ready_err", {m_ready_o, m_err_o}, 2'b11);
        check("both_no_strobe", {s_re_o, s_we_o}, 0);
        check("both_err_addr", err_addr_o, 32'h0001_0004);
        check("both_err_cnt", err_cnt_o, 3);
        tick();

        // A clean read after errors clears the flag
        start(1'b1, 1'b0, 32'h0001_0004, 32'h0);
        check("rd2_s_re", s_re_o, 4'b0100);
        tick();
        check("rd2_ready_err", {m_ready_o, m_err_o}, 2'b10);
        check("rd2_rdata", m_rdata_o, 32'h2222_2222);
        tick();

        // Strobe while busy is dropped
        start(1'b1, 1'b0, 32'h0001_0000, 32'h0);
        m_re_i   = 1'b1;
        m_addr_i = 32'h0001_0008;
        tick();
        m_re_i = 1'b0;
        check("busy_ready", m_ready_o, 1);
        tick();
        check("busy_ignored_busy", m_busy_o, 0);
        check("busy_ignored_s_re", s_re_o, 0);
        tick();
        check("busy_ignored_s_re2", s_re_o, 0);

        // Error counter saturation
        repeat (300) begin
            start(1'b1, 1'b0, 32'h0003_0000, 32'h0);
            tick();
        end
        check("sat_err_cnt", err_cnt_o, 255);
        check("sat_err_addr", err_addr_o, 32'h0003_0000);

        // Slot 2 never ready
        s_ready_i = 4'b1011;
        start(1'b0, 1'b1, 32'h0001_0004, 32'hA5);
        check("hang_s_we", s_we_o, 4'b0100);
`ifdef MMIO_TIMEOUT_EN
        cyc = 1;
        while (!m_ready_o && cyc < 40) begin
            tick();
            cyc++;
        end
        check("tmo_latency", cyc, 17);
        check("tmo_err", m_err_o, 1);
        check("tmo_s_we_drop", s_we_o, 0);
        check("tmo_err_addr", err_addr_o, 32'h0001_0004);
        check("tmo_err_cnt", err_cnt_o, 255);
        tick();
        check("tmo_idle", m_busy_o, 0);
`else
        cyc  = 0;
        seen = 1'b0;
        repeat (100) begin
            tick();
            seen |= m_ready_o;
            cyc++;
        end
        check("hang_cycles", cyc, 100);
        check("hang_no_ready", seen, 0);
        check("hang_busy", m_busy_o, 1);
        check("hang_s_we_held", s_we_o, 4'b0100);
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        check("hang_rst_s_we", s_we_o, 0);
        check("hang_rst_busy", m_busy_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmio_interconnect.md
Name: mmio_interconnect

Overview:
Parametrised data-side bus interconnect between the micro_riscv data port and N memory-mapped slaves (memory, stdin, stdout, gcd, future peripherals).
- Replaces the fixed combinational select/mux logic with a registered, handshaked transaction engine.
- Adds slave wait-states, decode-error responses for unmapped addresses and error capture registers.

Parameters:
N_SLV, 4, number of slave slots
ADDR_W, 32, address width
DATA_W, 32, data width
SLV_BASE, {32'h0001_0008, 32'h0001_0004, 32'h0001_0000, 32'h0000_0000}, packed N_SLV*ADDR_W slot base addresses, slot 0 in LSBs
SLV_SIZE, {32'd8, 32'd4, 32'd4, 32'h0001_0000}, packed N_SLV*ADDR_W slot sizes in bytes; 0 = slot disabled
TIMEOUT, 16, wait-state limit in cycles (used only with MMIO_TIMEOUT_EN)

Ports:
clk_i  in  1  clock; all logic on the rising edge
reset_i  in  1  synchronous, active-low reset
m_addr_i  in  ADDR_W  master address
m_wdata_i  in  DATA_W  master write data
m_re_i  in  1  read strobe, one cycle
m_we_i  in  1  write strobe, one cycle
m_busy_o  out  1  high when the transaction engine is not IDLE
m_ready_o  out  1  one-cycle completion pulse
m_err_o  out  1  error flag, valid with m_ready_o
m_rdata_o  out  DATA_W  read data; updates on completion and holds until the next completion
s_re_o  out  N_SLV  one-hot slave read enable
s_we_o  out  N_SLV  one-hot slave write enable
s_addr_o  out  ADDR_W  latched address minus the selected slot base
s_wdata_o  out  DATA_W  latched write data
s_rdata_i  in  N_SLV*DATA_W  packed slave read data
s_ready_i  in  N_SLV  slave done; tie high for zero wait-state slaves
err_addr_o  out  ADDR_W  address of the most recent faulting access
err_cnt_o  out  8  saturating fault counter

Behaviour:
- Reset (reset_i low at a clock edge):
  - FSM goes to IDLE.
  - Every output is driven to 0.
  - Slave strobes drop on the same edge; an in-flight transaction is abandoned with no m_ready_o.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - The engine samples m_re_i/m_we_i.
  - On a strobe it latches the address, write data, operation and decoded slot.
  - Mapped access → ACCESS.
  - Unmapped access → RESP with error.
- Strobes while m_busy_o=1 are ignored. Masters must wait for m_ready_o.
- m_re_i=1 and m_we_i=1 in the same cycle is a protocol error: → RESP with error, no slave access.
- Decode:
  - Slot i matches when SLV_BASE[i] ≤ addr < SLV_BASE[i]+SLV_SIZE[i].
  - The comparison uses ADDR_W+1 bits, so a slot ending at the top of the address space never wraps.
  - Lowest matching index wins.
  - SLV_SIZE=0 never matches.
- ACCESS:
  - s_re_o or s_we_o[slot] is held high, together with s_addr_o and s_wdata_o, until s_ready_i[slot]=1.
  - On the ready cycle, reads capture s_rdata_i[slot]; then → RESP.
  - s_ready_i of non-selected slots is ignored.
- RESP:
  - m_ready_o=1 for exactly one cycle, then → IDLE.
  - Read: m_rdata_o = captured data, m_err_o=0.
  - Write: m_rdata_o is unchanged.
- Error response:
  - m_err_o=1 and m_rdata_o=0 (never X).
  - err_addr_o ← latched address.
  - err_cnt_o increments and saturates at 255.
- Latency:
  - Zero-wait slave, strobe at cycle T → m_ready_o at T+2.
  - Each slave wait-state adds 1 cycle.
  - Decode error → m_ready_o at T+1.
- Back-to-back: the earliest next accepted strobe is the cycle after m_ready_o.

Optional Feature:
MMIO_TIMEOUT_EN
- Defined:
  - A counter clears on ACCESS entry and increments each ACCESS cycle.
  - If s_ready_i[slot] is still low when the counter reaches TIMEOUT, slave strobes drop and the FSM → RESP with error (err_addr_o and err_cnt_o updated).
  - A ready arriving on the same cycle as expiry wins: normal response.
- Undefined: no counter; ACCESS waits indefinitely. TIMEOUT is unused.

Decomposition:
- Package mmio_pkg: state enum (IDLE, ACCESS, RESP), ERR_CNT_W=8 constant, slot-index width function clog2(N_SLV).
- Sub-module mmio_addr_decode: purely combinational priority decoder.
  - Inputs: addr, SLV_BASE, SLV_SIZE.
  - Outputs: hit, slot index, offset.
  - Instantiated once on m_addr_i.

Test Plan:
- Reset mid-ACCESS with slot 0 stalled: on the edge with reset_i=0, all outputs are 0 and the FSM is IDLE; no m_ready_o afterwards.
- Read 0x0001_0000 with slot 1 ready tied high and s_rdata_i[1]=0xDEADBEEF:
  - s_re_o=4'b0010 and s_addr_o=0 at T+1.
  - m_ready_o=1, m_rdata_o=0xDEADBEEF, m_err_o=0 at T+2.
- Write 0x0001_0008 with data 0x12, slot 3 holding s_ready_i low 3 cycles:
  - s_we_o=4'b1000 held 4 cycles, s_addr_o=0, s_wdata_o=0x12.
  - m_ready_o at T+5.
- Read 0x0002_0000 (unmapped):
  - m_ready_o=1, m_err_o=1, m_rdata_o=0 at T+1.
  - err_addr_o=0x0002_0000, err_cnt_o=1.
- 300 unmapped accesses → err_cnt_o saturates at 255. A strobe during busy is ignored (no extra s_re_o).
- With MMIO_TIMEOUT_EN and slot 2 never ready: m_err_o=1 after 16 ACCESS cycles, s_we_o drops. Without the macro: still busy after 100 cycles.
